// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared FSM states, timeout defaults and byte width
// for the UART transmit arbiter and its round-robin helper.
package uart_ctrl_pkg;

  localparam int BYTE_W       = 8;
  localparam int START_TO_DEF = 16;
  localparam int DONE_TO_DEF  = 16384;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, search starts at i_last+1.
// Ports: i_req request vector, i_last previous winner, o_gnt one-hot, o_idx index.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx
);

  logic [W-1:0] w_pos;
  logic         w_found;

  // Walk N positions after i_last, wrapping at N-1; first hit wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = i_last;
    for (int k = 0; k < N; k++) begin
      w_pos = (w_pos == W'(N - 1)) ? '0 : w_pos + 1'b1;
      if (!w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte sources.
// Ports: req_* requester handshake, tx_* UART side, done_*/err_timeout status.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int START_TO = START_TO_DEF,
  parameter  int DONE_TO  = DONE_TO_DEF,
  localparam int IW       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic                      done_pulse,
  output logic [IW-1:0]             done_id,
  output logic                      err_timeout,
  output logic                      arb_busy
);

  localparam int TO_MAX = (START_TO > DONE_TO) ? START_TO : DONE_TO;
  localparam int CW     = $clog2(TO_MAX + 1);

  state_t              r_state;
  logic [BYTE_W-1:0]   r_data;
  logic [IW-1:0]       r_id;
  logic [IW-1:0]       r_last;
  logic                r_start;
  logic                r_done;
  logic                r_err;
  logic [CW-1:0]       r_cnt;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [IW-1:0]       w_idx;
  logic [BYTE_W-1:0]   w_byte;
  logic                w_idle;
  logic                w_accept;
  logic                w_cnt_sat;

  rr_arbiter #(
    .N (NUM_REQ),
    .W (IW)
  ) u_rr (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx)
  );

  // Grant is one-hot, so OR-ing masked bytes selects the winner's byte.
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_byte = w_byte | req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign w_idle    = (r_state == IDLE) && !rst;
  assign req_ready = w_idle ? w_gnt : '0;
  assign w_accept  = |req_ready;
  assign w_cnt_sat = &r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_id    <= '0;
      r_last  <= IW'(NUM_REQ - 1);
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data  <= w_byte;
            r_id    <= w_idx;
            r_last  <= w_idx;
            r_start <= 1'b1;
            r_cnt   <= '0;
            r_state <= START;
          end
        end
        START: begin
          // A done seen before busy means busy was missed.
          if (tx_done) begin
            r_start <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (tx_busy) begin
            r_start <= 1'b0;
            r_cnt   <= '0;
            r_state <= WAIT_DONE;
          end else if (r_cnt == CW'(START_TO - 1)) begin
            r_start <= 1'b0;
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (!w_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (r_cnt == CW'(DONE_TO - 1)) begin
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (!w_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_start <= 1'b0;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx_start    = r_start;
  assign tx_data     = r_data;
  assign done_pulse  = r_done;
  assign err_timeout = r_err;
  assign done_id     = r_id;
  assign arb_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table vectors, hand sequences and random frames
// checked against a transaction-level round-robin / latency model.
module tb_uart_tx_arbiter;

  localparam int N      = 4;
  localparam int STO    = 16;
  localparam int DTO    = 16384;
  localparam int S_NORM = 0;
  localparam int S_STO  = 1;
  localparam int S_MISS = 2;
  localparam int S_DTO  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           tx_done;
  logic           done_pulse;
  logic [1:0]     done_id;
  logic           err_timeout;
  logic           arb_busy;

  int checks = 0;
  int errors = 0;
  int last_g;
  bit rand_valid;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ  (N),
    .START_TO (STO),
    .DONE_TO  (DTO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .done_pulse  (done_pulse),
    .done_id     (done_id),
    .err_timeout (err_timeout),
    .arb_busy    (arb_busy)
  );

  typedef struct {
    logic [3:0]  v;
    logic [31:0] dat;
    int          scen;
    int          d1;
    int          d2;
    int          eg;
  } vec_t;

  localparam int NT = 12;
  vec_t tbl [NT];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v);
    int i;
    for (int k = 1; k <= N; k++) begin
      i = (last_g + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic offer(input logic [N-1:0] v, output int w);
    req_valid = v;
    #1;
    w = rr_pick(v);
    chk("ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
  endtask

  task automatic run_frame(input int w, input int scen,
                           input int d1, input int d2);
    logic [7:0] b;
    int         endr;
    bit         isdone;
    b      = req_data[w*8 +: 8];
    last_g = w;
    case (scen)
      S_NORM:  endr = d1 + d2 + 2;
      S_STO:   endr = STO;
      S_MISS:  endr = d1 + 1;
      default: endr = d1 + 1 + DTO;
    endcase
    isdone = (scen == S_NORM) || (scen == S_MISS);
    for (int r = 0; r <= endr; r++) begin
      bit sh, bz, dn;
      @(negedge clk);
      sh = (scen == S_STO) ? (r < STO) : (r <= d1);
      chk("frame",
          32'({tx_start, done_pulse, err_timeout, arb_busy, tx_data}),
          32'({sh, (r == endr) && isdone, (r == endr) && !isdone,
               r < endr, b}));
      if (r == endr) begin
        chk("done_id", 32'(done_id), 32'(w));
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        req_valid = '0;
      end else begin
        bz = (scen == S_NORM && r >= d1 && r <= d1 + 1 + d2) ||
             (scen == S_DTO && r >= d1);
        dn = (scen == S_NORM && r == d1 + 1 + d2) ||
             (scen == S_MISS && r == d1);
        tx_busy = bz;
        tx_done = dn;
        if (rand_valid) req_valid = N'($urandom);
        else req_valid = (r == 1) ? 4'b0100 : 4'b0000;
        #1;
        chk("ready_busy", 32'(req_ready), 32'd0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int s;
    int sc;
    logic [3:0] v;
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    tx_busy    = 1'b0;
    tx_done    = 1'b0;
    rand_valid = 1'b1;
    last_g     = N - 1;

    repeat (3) @(negedge clk);
    req_valid = '1;
    #1;
    chk("ready_in_rst", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state",
        32'({tx_start, tx_data, done_pulse, err_timeout, done_id, arb_busy}),
        32'd0);

    tbl[0]  = '{4'b1111, 32'h43322110, S_NORM, 1, 2, 0};
    tbl[1]  = '{4'b1111, 32'h43322110, S_NORM, 0, 0, 1};
    tbl[2]  = '{4'b1111, 32'h43322110, S_NORM, 3, 1, 2};
    tbl[3]  = '{4'b1111, 32'h43322110, S_NORM, 2, 5, 3};
    tbl[4]  = '{4'b1111, 32'h43322110, S_NORM, 0, 3, 0};
    tbl[5]  = '{4'b0001, 32'h000000A5, S_NORM, 2, 3, 0};
    tbl[6]  = '{4'b0000, 32'h000000A5, S_NORM, 0, 0, -1};
    tbl[7]  = '{4'b0110, 32'h43322110, S_STO,  0, 0, 1};
    tbl[8]  = '{4'b0110, 32'h43322110, S_MISS, 3, 0, 2};
    tbl[9]  = '{4'b1001, 32'h43322110, S_NORM, 1, 1, 3};
    tbl[10] = '{4'b1001, 32'h43322110, S_NORM, 0, 0, 0};
    tbl[11] = '{4'b1111, 32'h43322110, S_MISS, 0, 0, 1};

    for (int i = 0; i < NT; i++) begin
      req_data = tbl[i].dat;
      offer(tbl[i].v, w);
      chk("grant_tbl", 32'(req_ready),
          (tbl[i].eg < 0) ? 32'd0 : (32'd1 << tbl[i].eg));
      if (w >= 0) begin
        run_frame(w, tbl[i].scen, tbl[i].d1, tbl[i].d2);
      end else begin
        @(negedge clk);
        chk("idle_stay", 32'({arb_busy, tx_start}), 32'd0);
      end
    end

    rand_valid = 1'b0;
    req_data   = 32'h43322110;
    offer(4'b0001, w);
    run_frame(w, S_NORM, 2, 2);
    offer(4'b1000, w);
    chk("withdraw_grant", 32'(req_ready), 32'h8);
    if (w >= 0) run_frame(w, S_NORM, 1, 1);
    offer(4'b0000, w);
    @(negedge clk);

    offer(4'b0100, w);
    if (w >= 0) run_frame(w, S_DTO, 1, 0);

    offer(4'b0010, w);
    @(negedge clk);
    chk("rst_pre_start", 32'(tx_start), 32'd1);
    tx_busy   = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    chk("rst_pre_busy", 32'(arb_busy), 32'd1);
    rst       = 1'b1;
    req_valid = '1;
    last_g    = N - 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("in_rst",
          32'({done_pulse, err_timeout, req_ready, tx_start}), 32'd0);
    end
    rst       = 1'b0;
    tx_busy   = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("post_rst",
        32'({tx_start, arb_busy, req_ready, done_pulse, err_timeout}),
        32'd0);
    offer(4'b1111, w);
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    if (w >= 0) run_frame(w, S_NORM, 0, 1);

    rand_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      req_data = $urandom;
      v        = 4'($urandom_range(0, 15));
      offer(v, w);
      if (w < 0) begin
        @(negedge clk);
        chk("rand_idle", 32'(arb_busy), 32'd0);
      end else begin
        s  = int'($urandom_range(0, 19));
        sc = (s < 14) ? S_NORM : (s < 17) ? S_MISS : S_STO;
        run_frame(w, sc, int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 8)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
